// File: rtl/hazard_ctrl_unit.sv
// Stateful hazard/forwarding controller for a 5-stage MIPS pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             BranchFlush,
  input  logic             JumpFlush,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic [REG_W-1:0] IDEX_Rs,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_wsel,
  input  logic             ex_mc_start,
  input  logic             EXMEM_RegWr,
  input  logic [REG_W-1:0] EXMEM_wsel,
  input  logic             MEMWB_RegWr,
  input  logic [REG_W-1:0] MEMWB_wsel,
  output logic             pcWEN,
  output logic             IFID_enable,
  output logic             IDEX_enable,
  output logic             EXMEM_enable,
  output logic             MEMWB_enable,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] bubble_count
`endif
);

  localparam int MCW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'((MC_LAT > 2) ? (MC_LAT - 2) : 0);
  localparam logic MC_EN = (MC_LAT > 1);

  typedef enum logic {RUN = 1'b0, MCBUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [MCW-1:0]   r_cnt, w_cnt_nxt;
  logic             r_mc_done, w_mc_done_nxt;
  logic [1:0]       r_flush_pend, w_flush_pend_nxt;

  logic w_dstall, w_mc_req, w_mstall, w_adv;
  logic w_br, w_jp, w_lu_hz, w_bubble;

  assign w_dstall = dmem_req & ~dhit;
  assign w_mc_req = (r_state == RUN) & ex_mc_start & ~r_mc_done & MC_EN;
  assign w_mstall = (r_state == MCBUSY) | w_mc_req;
  assign w_adv    = ihit & ~w_dstall & ~w_mstall;
  assign w_br     = BranchFlush | r_flush_pend[1];
  assign w_jp     = JumpFlush | r_flush_pend[0];
  assign w_lu_hz  = IDEX_MemRead & (IDEX_wsel != '0) &
                    ((IDEX_wsel == IFID_Rs) | (IDEX_wsel == IFID_Rt));
  assign w_bubble = w_adv & ~w_br & ~w_jp & w_lu_hz;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_mc_done    <= 1'b0;
      r_flush_pend <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mc_done    <= w_mc_done_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // The RUN cycle that detects the op is the first stall cycle, so MCBUSY
  // lasts MC_LAT-2 cycles and EX advances in the MC_LAT-th cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_mc_done_nxt    = r_mc_done;
    w_flush_pend_nxt = r_flush_pend;
    case (r_state)
      RUN: begin
        if (w_mc_req) begin
          if (MC_LAT == 2) begin
            w_mc_done_nxt = 1'b1;
          end else begin
            w_state_nxt = MCBUSY;
            w_cnt_nxt   = MC_LOAD;
          end
        end
      end
      MCBUSY: begin
        if (r_cnt <= MCW'(1)) begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = '0;
          w_mc_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - MCW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_adv) begin
      w_mc_done_nxt    = 1'b0;
      w_flush_pend_nxt = 2'b00;
    end else if (w_br) begin
      w_flush_pend_nxt = 2'b10;
    end else if (w_jp) begin
      w_flush_pend_nxt = 2'b01;
    end
  end

  always_comb begin
    pcWEN        = 1'b0;
    IFID_enable  = 1'b0;
    IDEX_enable  = 1'b0;
    EXMEM_enable = 1'b0;
    MEMWB_enable = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_flush  = 1'b0;
    forwardA     = 2'b00;
    forwardB     = 2'b00;
    mc_busy      = 1'b0;
    if (nRST) begin
      mc_busy = (r_state == MCBUSY);
      if (EXMEM_RegWr && (EXMEM_wsel != '0) && (EXMEM_wsel == IDEX_Rs))
        forwardA = 2'b01;
      else if (MEMWB_RegWr && (MEMWB_wsel != '0) && (MEMWB_wsel == IDEX_Rs))
        forwardA = 2'b10;
      if (EXMEM_RegWr && (EXMEM_wsel != '0) && (EXMEM_wsel == IDEX_Rt))
        forwardB = 2'b01;
      else if (MEMWB_RegWr && (MEMWB_wsel != '0) && (MEMWB_wsel == IDEX_Rt))
        forwardB = 2'b10;
      if (w_adv) begin
        pcWEN        = 1'b1;
        IFID_enable  = 1'b1;
        IDEX_enable  = 1'b1;
        EXMEM_enable = 1'b1;
        MEMWB_enable = 1'b1;
        if (w_br) begin
          IFID_flush  = 1'b1;
          IDEX_flush  = 1'b1;
          EXMEM_flush = 1'b1;
        end else if (w_jp) begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end else if (w_bubble) begin
          pcWEN       = 1'b0;
          IFID_enable = 1'b0;
          IDEX_flush  = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count, r_bubble_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (!w_adv && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_adv && (w_br || w_jp) && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
      if (w_bubble && (r_bubble_count != '1))
        r_bubble_count <= r_bubble_count + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised next-generation hazard/forwarding controller for the 5-stage MIPS pipeline.
- Adds stateful handling on top of the base hazard unit:
  - load-use bubble insertion;
  - multi-cycle EX-operation stall counter;
  - data-memory wait state;
  - a pending-flush latch, so flushes requested during a freeze are not lost.
- Sits beside the datapath latches; drives the PC write enable, latch enables/flushes and forwarding selects.

Parameters:
- REG_W, 5, register-index width.
- MC_LAT, 4, EX latency in cycles of a multi-cycle op (>=1; 1 means no stall).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- CLK  in  1  system clock
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dmem_req  in  1  EX/MEM holds a load/store
- BranchFlush  in  1  taken/mispredicted branch resolved in MEM
- JumpFlush  in  1  jump resolved in EX
- IFID_Rs  in  REG_W  rs of instruction in ID
- IFID_Rt  in  REG_W  rt of instruction in ID
- IDEX_Rs  in  REG_W  rs of instruction in EX
- IDEX_Rt  in  REG_W  rt of instruction in EX
- IDEX_MemRead  in  1  EX instruction is a load
- IDEX_wsel  in  REG_W  dest register of EX instruction
- ex_mc_start  in  1  EX instruction is multi-cycle
- EXMEM_RegWr  in  1  write enable, MEM stage
- EXMEM_wsel  in  REG_W  dest register, MEM stage
- MEMWB_RegWr  in  1  write enable, WB stage
- MEMWB_wsel  in  REG_W  dest register, WB stage
- pcWEN  out  1  PC write enable
- IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable  out  1 each  latch enables
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  latch flushes
- forwardA  out  2  EX operand A select
- forwardB  out  2  EX operand B select
- mc_busy  out  1  multi-cycle counter active

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - nRST is asynchronous, active-low.
  - While nRST=0, all outputs are 0. State returns to RUN, cnt=0, flush_pend=0, mc_done=0.
- State machine (registered): RUN, MCBUSY.
  - RUN -> MCBUSY when ex_mc_start=1, mc_done=0, MC_LAT>1 and no flush is applied this cycle; cnt loads MC_LAT-2.
  - MCBUSY: cnt decrements each cycle. At cnt==0 -> RUN and mc_done is set.
  - mc_done clears on any cycle in which IDEX advances.
  - mc_busy = (state==MCBUSY).
- Stall terms:
  - dstall = dmem_req & ~dhit
  - mstall = (state==MCBUSY) | (RUN & ex_mc_start & ~mc_done & MC_LAT>1)
  - adv = ihit & ~dstall & ~mstall
- Freeze (adv=0):
  - pcWEN and all enables are 0; all flushes are 0.
  - Any BranchFlush/JumpFlush this cycle sets flush_pend: 2'b10 for branch (dominates), 2'b01 for jump.
- Advance (adv=1):
  - All enables are 1 and pcWEN=1, except as modified below.
  - Branch (BranchFlush | flush_pend[1]): IFID_flush, IDEX_flush and EXMEM_flush are 1.
  - Jump (JumpFlush | flush_pend[0]), no branch: IFID_flush and IDEX_flush are 1.
  - flush_pend clears.
  - Load-use, only when no flush applies:
    - Condition: IDEX_MemRead, IDEX_wsel!=0, and IDEX_wsel==IFID_Rs or IDEX_wsel==IFID_Rt.
    - Response: pcWEN=0, IFID_enable=0, IDEX_flush=1. Exactly one bubble per hazard.
- Forwarding (combinational, independent of stalls):
  - forwardA = 2'b01 if EXMEM_RegWr, EXMEM_wsel!=0 and EXMEM_wsel==IDEX_Rs.
  - Otherwise forwardA = 2'b10 if the same test passes on MEMWB.
  - Otherwise forwardA = 2'b00.
  - forwardB is identical, using IDEX_Rt.
  - Register 0 is never forwarded. MEM has priority over WB.
- Simultaneous events:
  - dstall and mstall together: freeze until both clear.
  - Reset mid-MCBUSY aborts the counter; flush_pend is discarded.

Optional Feature:
- HAZARD_PERF_CNT_EN defined adds outputs stall_cycles [CNT_W], flush_count [CNT_W] and bubble_count [CNT_W]:
  - stall_cycles increments on every adv=0 cycle.
  - flush_count increments on every applied flush.
  - bubble_count increments on every load-use bubble.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: nRST=0 mid-MCBUSY (cnt=2) -> all outputs 0 immediately; after release with ihit=1, pcWEN=1 and state RUN.
- Load-use: IDEX_MemRead=1, IDEX_wsel=8, IFID_Rs=8, ihit=1 -> one cycle with pcWEN=0, IFID_enable=0, IDEX_flush=1; next cycle normal. Repeat with IDEX_wsel=0 -> no bubble.
- Multi-cycle, MC_LAT=4: ex_mc_start=1, ihit=1 -> enables 0 for exactly 3 cycles, mc_busy=1 on cycles 2-3; cycle 4 advances with no re-entry.
- Pending flush: dmem_req=1, dhit=0 for 3 cycles, BranchFlush pulsed in cycle 1 -> no flush while frozen; in the first cycle dhit=1, IFID_flush, IDEX_flush and EXMEM_flush are all 1.
- Forwarding: EXMEM_wsel=MEMWB_wsel=IDEX_Rs=5, both RegWr=1 -> forwardA=01; EXMEM_RegWr=0 -> 10; all wsel=0 -> 00.
- HAZARD_PERF_CNT_EN with CNT_W=2: 5 freeze cycles -> stall_cycles=3 (saturated).
